// File: rtl/instr_decode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : instr_decode_pkg                                             |
// | Description : Shared opcode constants, class bit order and decoded record  |
// |               for the RV32I decode stage. When DECODE_ILLEGAL_EN is        |
// |               defined the decoded record carries an illegal flag.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package instr_decode_pkg;

    // RV32I base opcodes, instr[6:0]
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    localparam int NUM_TYPES = 9;

    // Bit position of each class inside the one-hot out_type vector
    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_LOAD   = 4'd1,
        CLS_OP_IMM = 4'd2,
        CLS_JALR   = 4'd3,
        CLS_S      = 4'd4,
        CLS_B      = 4'd5,
        CLS_AUIPC  = 4'd6,
        CLS_LUI    = 4'd7,
        CLS_JAL    = 4'd8
    } instr_class_e;

    // Decoded instruction fields. Every RV32I immediate fits in 32 bits, so
    // imm is kept at 32 bits here and sign-extended to XLEN at the stage
    // output; the XLEN-wide pc travels next to this record in the stage.
    typedef struct packed {
        logic [NUM_TYPES-1:0] itype;
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
        logic [31:0]          imm;
`ifdef DECODE_ILLEGAL_EN
        logic                 illegal;
`endif
    } decoded_t;

    // One-hot vector with only the bit for class c set
    function automatic logic [NUM_TYPES-1:0] class_onehot(input instr_class_e c);
        logic [NUM_TYPES-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_field_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_field_decode                                           |
// | Description : Purely combinational RV32I field decoder: raw instruction    |
// |               word to class one-hot, register indices, funct fields and    |
// |               sign-extended immediate. DECODE_ILLEGAL_EN adds the illegal  |
// |               flag (bad length bits or unknown opcode).                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_field_decode
    import instr_decode_pkg::*;
(
    input  logic [31:0] instr,
    output decoded_t    dec
);

    logic [31:0]  w_imm_i;
    logic [31:0]  w_imm_s;
    logic [31:0]  w_imm_b;
    logic [31:0]  w_imm_u;
    logic [31:0]  w_imm_j;
    logic         w_known;
    instr_class_e w_cls;
    logic [31:0]  w_imm;

    // Build every immediate format in parallel; the opcode picks one below
    always_comb begin
        w_imm_i = {{20{instr[31]}}, instr[31:20]};
        w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        w_imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        w_imm_u = {instr[31:12], 12'h000};
        w_imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    end

    // Opcode to class and immediate select; the full 7-bit compare also
    // rejects words whose length bits are not 2'b11
    always_comb begin
        w_known = 1'b1;
        w_cls   = CLS_R;
        w_imm   = 32'h0;
        case (instr[6:0])
            OPC_OP:     begin w_cls = CLS_R;      w_imm = 32'h0;   end
            OPC_LOAD:   begin w_cls = CLS_LOAD;   w_imm = w_imm_i; end
            OPC_OP_IMM: begin w_cls = CLS_OP_IMM; w_imm = w_imm_i; end
            OPC_JALR:   begin w_cls = CLS_JALR;   w_imm = w_imm_i; end
            OPC_STORE:  begin w_cls = CLS_S;      w_imm = w_imm_s; end
            OPC_BRANCH: begin w_cls = CLS_B;      w_imm = w_imm_b; end
            OPC_AUIPC:  begin w_cls = CLS_AUIPC;  w_imm = w_imm_u; end
            OPC_LUI:    begin w_cls = CLS_LUI;    w_imm = w_imm_u; end
            OPC_JAL:    begin w_cls = CLS_JAL;    w_imm = w_imm_j; end
            default:    begin w_known = 1'b0;     w_imm = 32'h0;   end
        endcase
    end

    // Assemble the decoded record; unknown encodings give an all-zero class
    always_comb begin
        dec.rd     = instr[11:7];
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.funct3 = instr[14:12];
        dec.funct7 = instr[31:25];
        dec.imm    = w_imm;
`ifdef DECODE_ILLEGAL_EN
        dec.illegal = (instr[1:0] != 2'b11) || !w_known;
        dec.itype   = dec.illegal ? '0 : class_onehot(w_cls);
`else
        dec.itype   = w_known ? class_onehot(w_cls) : '0;
`endif
    end

endmodule
`default_nettype wire

// File: rtl/instr_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_decode_stage                                           |
// | Description : Registered RV32I decode stage with valid/ready on both sides |
// |               and a two-entry skid (output register OR + skid register SK) |
// |               giving full throughput with a registered in_ready. Counts    |
// |               completed output handshakes. DECODE_ILLEGAL_EN adds the      |
// |               out_illegal port.                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_decode_stage
    import instr_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [NUM_TYPES-1:0] out_type,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [2:0]           out_funct3,
    output logic [6:0]           out_funct7,
    output logic [XLEN-1:0]      out_imm,
`ifdef DECODE_ILLEGAL_EN
    output logic                 out_illegal,
`endif
    output logic [CNT_W-1:0]     decode_count
);

    // One buffered entry: pc at full width plus the decoded fields
    typedef struct packed {
        logic [XLEN-1:0] pc;
        decoded_t        dec;
    } stage_t;

    decoded_t         w_in_dec;
    stage_t           w_in_stage;
    logic             w_in_fire;
    logic             w_out_fire;

    stage_t           or_q, or_d;
    logic             or_valid_q, or_valid_d;
    stage_t           sk_q, sk_d;
    logic             sk_valid_q, sk_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Decode happens on the way in, so SK holds already-decoded fields
    instr_field_decode u_field_decode (
        .instr (in_instr),
        .dec   (w_in_dec)
    );

    assign w_in_stage.pc  = in_pc;
    assign w_in_stage.dec = w_in_dec;
    assign w_in_fire      = in_valid && in_ready_q;
    assign w_out_fire     = or_valid_q && out_ready;

    // Next-state for OR/SK: SK refills OR first, so ordering stays FIFO
    always_comb begin
        or_d       = or_q;
        or_valid_d = or_valid_q;
        sk_d       = sk_q;
        sk_valid_d = sk_valid_q;
        count_d    = count_q + CNT_W'(w_out_fire);
        if (flush) begin
            // Input handshake this cycle is dropped; the output one still counts
            or_valid_d = 1'b0;
            sk_valid_d = 1'b0;
        end else if (!or_valid_q || w_out_fire) begin
            if (sk_valid_q) begin
                // in_ready is low while SK is full, so no new input competes here
                or_d       = sk_q;
                or_valid_d = 1'b1;
                sk_valid_d = 1'b0;
            end else if (w_in_fire) begin
                or_d       = w_in_stage;
                or_valid_d = 1'b1;
            end else begin
                or_valid_d = 1'b0;
            end
        end else if (w_in_fire) begin
            sk_d       = w_in_stage;
            sk_valid_d = 1'b1;
        end
        in_ready_d = !sk_valid_d;
    end

    // State registers; reset clears the data path as well as the valids
    always_ff @(posedge clk) begin
        if (rst) begin
            or_q       <= '0;
            or_valid_q <= 1'b0;
            sk_q       <= '0;
            sk_valid_q <= 1'b0;
            in_ready_q <= 1'b1;
            count_q    <= '0;
        end else begin
            or_q       <= or_d;
            or_valid_q <= or_valid_d;
            sk_q       <= sk_d;
            sk_valid_q <= sk_valid_d;
            in_ready_q <= in_ready_d;
            count_q    <= count_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = or_valid_q;
    assign out_pc       = or_q.pc;
    assign out_type     = or_q.dec.itype;
    assign out_rd       = or_q.dec.rd;
    assign out_rs1      = or_q.dec.rs1;
    assign out_rs2      = or_q.dec.rs2;
    assign out_funct3   = or_q.dec.funct3;
    assign out_funct7   = or_q.dec.funct7;
    assign decode_count = count_q;
`ifdef DECODE_ILLEGAL_EN
    assign out_illegal  = or_q.dec.illegal;
`endif

    // Widen the 32-bit immediate to XLEN by sign extension
    generate
        if (XLEN > 32) begin : g_imm_ext
            assign out_imm = {{(XLEN-32){or_q.dec.imm[31]}}, or_q.dec.imm};
        end else begin : g_imm_direct
            assign out_imm = or_q.dec.imm;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_decode_stage                                        |
// | Description : Self-checking bench for instr_decode_stage: directed vector  |
// |               table, back-pressure / flush / wrap / reset sequences and a  |
// |               randomized run against a queue-based reference model.        |
// |               Honours DECODE_ILLEGAL_EN.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instr_decode_stage;
    import instr_decode_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic                 clk = 1'b0;
    logic                 rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]          in_instr;
    logic [XLEN-1:0]      in_pc, out_pc, out_imm;
    logic [NUM_TYPES-1:0] out_type;
    logic [4:0]           out_rd, out_rs1, out_rs2;
    logic [2:0]           out_funct3;
    logic [6:0]           out_funct7;
    logic [CNT_W-1:0]     decode_count;
`ifdef DECODE_ILLEGAL_EN
    logic                 out_illegal;
`endif

    always #5 clk = ~clk;

    instr_decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_type     (out_type),
        .out_rd       (out_rd),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_funct3   (out_funct3),
        .out_funct7   (out_funct7),
        .out_imm      (out_imm),
`ifdef DECODE_ILLEGAL_EN
        .out_illegal  (out_illegal),
`endif
        .decode_count (decode_count)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_count = 0;

    typedef struct {
        logic [NUM_TYPES-1:0] itype;
        logic [31:0]          imm;
        logic                 illegal;
    } ref_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        ref_t        r;
    } pkt_t;

    typedef struct {
        logic [31:0]          instr;
        logic [NUM_TYPES-1:0] exp_type;
        logic [4:0]           exp_rd;
        logic [4:0]           exp_rs1;
        logic [31:0]          exp_imm;
    } vec_t;

    pkt_t model_q[$];

    function automatic logic [NUM_TYPES-1:0] oh(input instr_class_e c);
        logic [NUM_TYPES-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // Reference decode: immediates from weighted bit fields with plain arithmetic
    function automatic ref_t ref_decode(input logic [31:0] i);
        ref_t r;
        r.itype   = '0;
        r.imm     = 32'h0;
        r.illegal = 1'b0;
        case (i[6:0])
            7'h33: r.itype = oh(CLS_R);
            7'h03: begin r.itype = oh(CLS_LOAD);   r.imm = $signed(i) >>> 20; end
            7'h13: begin r.itype = oh(CLS_OP_IMM); r.imm = $signed(i) >>> 20; end
            7'h67: begin r.itype = oh(CLS_JALR);   r.imm = $signed(i) >>> 20; end
            7'h23: begin
                r.itype = oh(CLS_S);
                r.imm   = (($signed(i) >>> 25) * 32) + int'(i[11:7]);
            end
            7'h63: begin
                r.itype = oh(CLS_B);
                r.imm   = (i[31] ? -4096 : 0) + int'(i[7]) * 2048
                        + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            end
            7'h17: begin r.itype = oh(CLS_AUIPC); r.imm = i & 32'hFFFF_F000; end
            7'h37: begin r.itype = oh(CLS_LUI);   r.imm = i & 32'hFFFF_F000; end
            7'h6F: begin
                r.itype = oh(CLS_JAL);
                r.imm   = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096
                        + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            end
            default: r.itype = '0;
        endcase
`ifdef DECODE_ILLEGAL_EN
        r.illegal = (r.itype == '0) || (i[1:0] != 2'b11);
        if (r.illegal) r.itype = '0;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every output field with an expected packet
    task automatic check_pkt(input string tag, input pkt_t p);
        check($sformatf("%s.pc", tag),     out_pc,     p.pc);
        check($sformatf("%s.type", tag),   out_type,   p.r.itype);
        check($sformatf("%s.rd", tag),     out_rd,     p.instr[11:7]);
        check($sformatf("%s.rs1", tag),    out_rs1,    p.instr[19:15]);
        check($sformatf("%s.rs2", tag),    out_rs2,    p.instr[24:20]);
        check($sformatf("%s.funct3", tag), out_funct3, p.instr[14:12]);
        check($sformatf("%s.funct7", tag), out_funct7, p.instr[31:25]);
        check($sformatf("%s.imm", tag),    out_imm,    p.r.imm);
`ifdef DECODE_ILLEGAL_EN
        check($sformatf("%s.illegal", tag), out_illegal, p.r.illegal);
`endif
    endtask

    function automatic pkt_t mk(input logic [31:0] instr, input logic [31:0] pc);
        pkt_t p;
        p.instr = instr;
        p.pc    = pc;
        p.r     = ref_decode(instr);
        return p;
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = '0;
        tick(); tick();
        rst = 1'b0;
        exp_count = 0;
        model_q.delete();
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
    endtask

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        pkt_t pa, pb, pc;
        vecs[0]  = '{32'hFFF10093, oh(CLS_OP_IMM), 5'd1,  5'd2,  32'hFFFF_FFFF};
        vecs[1]  = '{32'h123452B7, oh(CLS_LUI),    5'd5,  5'd8,  32'h1234_5000};
        vecs[2]  = '{32'hFE000EE3, oh(CLS_B),      5'd29, 5'd0,  32'hFFFF_FFFC};
        vecs[3]  = '{32'h00512423, oh(CLS_S),      5'd8,  5'd2,  32'h0000_0008};
        vecs[4]  = '{32'h8000006F, oh(CLS_JAL),    5'd0,  5'd0,  32'hFFF0_0000};
        vecs[5]  = '{32'h002081B3, oh(CLS_R),      5'd3,  5'd1,  32'h0000_0000};
        vecs[6]  = '{32'hFFFFF517, oh(CLS_AUIPC),  5'd10, 5'd31, 32'hFFFF_F000};
        vecs[7]  = '{32'h004280E7, oh(CLS_JALR),   5'd1,  5'd5,  32'h0000_0004};
        vecs[8]  = '{32'hFFC3A303, oh(CLS_LOAD),   5'd6,  5'd7,  32'hFFFF_FFFC};
        vecs[9]  = '{32'h0000007F, '0,             5'd0,  5'd0,  32'h0000_0000};
        vecs[10] = '{32'h00000010, '0,             5'd0,  5'd0,  32'h0000_0000};

        do_reset();
        check("reset.out_valid", out_valid, 1'b0);
        check("reset.in_ready",  in_ready,  1'b1);
        check("reset.count",     decode_count, 0);
        check("reset.pc",        out_pc, 0);
        check("reset.type",      out_type, 0);
        check("reset.imm",       out_imm, 0);
`ifdef DECODE_ILLEGAL_EN
        check("reset.illegal",   out_illegal, 1'b0);
`endif

        // Directed vector table, one instruction at a time with out_ready high
        out_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            push(vecs[k].instr, 32'h1000 + 32'(k) * 4);
            tick();
            in_valid = 1'b0;
            check($sformatf("vec%0d.out_valid", k), out_valid, 1'b1);
            check($sformatf("vec%0d.type", k), out_type, vecs[k].exp_type);
            check($sformatf("vec%0d.rd", k),   out_rd,   vecs[k].exp_rd);
            check($sformatf("vec%0d.rs1", k),  out_rs1,  vecs[k].exp_rs1);
            check($sformatf("vec%0d.imm", k),  out_imm,  vecs[k].exp_imm);
            check($sformatf("vec%0d.pc", k),   out_pc,   32'h1000 + 32'(k) * 4);
`ifdef DECODE_ILLEGAL_EN
            check($sformatf("vec%0d.illegal", k), out_illegal, vecs[k].exp_type == '0);
`endif
            tick();
            exp_count++;
            check($sformatf("vec%0d.count", k), decode_count, exp_count % 16);
            check($sformatf("vec%0d.drained", k), out_valid, 1'b0);
        end

        // Back-pressure: A to OR, B to SK, C held off until space frees
        pa = mk(32'h00100093, 32'h2000);
        pb = mk(32'h00200113, 32'h2004);
        pc = mk(32'h00300193, 32'h2008);
        out_ready = 1'b0;
        push(pa.instr, pa.pc); tick();
        push(pb.instr, pb.pc); tick();
        push(pc.instr, pc.pc);
        check("bp.in_ready_full", in_ready, 1'b0);
        check_pkt("bp.hold_a", pa);
        tick();
        check("bp.in_ready_held", in_ready, 1'b0);
        check_pkt("bp.stable_a", pa);
        out_ready = 1'b1;
        tick();
        check_pkt("bp.b", pb);
        check("bp.in_ready_free", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check_pkt("bp.c", pc);
        tick();
        exp_count += 3;
        check("bp.empty", out_valid, 1'b0);
        check("bp.count", decode_count, exp_count % 16);

        // Flush with both entries full and a concurrent input
        out_ready = 1'b0;
        push(pa.instr, pa.pc); tick();
        push(pb.instr, pb.pc); tick();
        push(pc.instr, pc.pc); flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush.out_valid", out_valid, 1'b0);
        check("flush.in_ready",  in_ready,  1'b1);
        check("flush.count",     decode_count, exp_count % 16);
        tick();
        check("flush.dropped",   out_valid, 1'b0);

        // Counter wrap: 17 handshakes from a fresh reset on a 4-bit counter
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            push(32'h00000013, 32'h3000 + 32'(k) * 4);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("wrap.count", decode_count, 1);

        // Reset in the middle of a stall
        out_ready = 1'b0;
        push(pa.instr, pa.pc); tick();
        push(pb.instr, pb.pc); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("rstmid.out_valid", out_valid, 1'b0);
        check("rstmid.in_ready",  in_ready,  1'b1);
        check("rstmid.count",     decode_count, 0);
        check("rstmid.imm",       out_imm, 0);
        exp_count = 0;
        model_q.delete();

        // Randomized traffic against the queue model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [31:0] rnd, instr;
            logic [6:0]  opc;
            logic        out_f, in_f;
            check("rnd.out_valid", out_valid, model_q.size() != 0);
            check("rnd.in_ready",  in_ready,  model_q.size() < 2);
            check("rnd.count",     decode_count, exp_count % 16);
            if (model_q.size() != 0) check_pkt("rnd", model_q[0]);

            rnd = $urandom();
            case ($urandom_range(0, 9))
                0: opc = 7'h33; 1: opc = 7'h03; 2: opc = 7'h13; 3: opc = 7'h67;
                4: opc = 7'h23; 5: opc = 7'h63; 6: opc = 7'h17; 7: opc = 7'h37;
                8: opc = 7'h6F;
                default: opc = rnd[6:0];
            endcase
            instr     = {rnd[31:7], opc};
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_instr  = instr;
            in_pc     = $urandom();

            out_f = (model_q.size() != 0) && out_ready;
            in_f  = in_valid && (model_q.size() < 2);
            if (out_f) begin
                void'(model_q.pop_front());
                exp_count++;
            end
            if (flush) model_q.delete();
            else if (in_f) model_q.push_back(mk(in_instr, in_pc));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
